// File: rtl/entropy_pkg.sv
// Shared types and constants for the entropy-calc packet buffer port logic.
// Holds the arbiter state encoding, requester ids and the read-return tag format.
package entropy_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StOwn0 = ST_OWN0,
        StOwn1 = ST_OWN1
    } arb_state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    function automatic arb_state_e own_state(input logic id);
        return (id == REQ_ID1) ? StOwn1 : StOwn0;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Latency-matched shift register of read tags; the last stage lines up with
// the BRAM read data so the owner field can steer each returning word.
module rd_tag_pipe
    import entropy_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag,
    output logic    o_any_valid
);

    rd_tag_t [DEPTH-1:0] stage_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_any_valid = o_any_valid | stage_q[i].valid;
        end
    end

    assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for BRAM port B with burst locking and a
// fairness cap; registers the winning beat onto the port and routes reads back.
module bram_port_arbiter
    import entropy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,

    input  logic                      i_req0,
    input  logic                      i_lock0,
    input  logic [ADDR_WIDTH-1:0]     i_addr0,
    input  logic [DATA_WIDTH-1:0]     i_din0,
    input  logic [DATA_WIDTH/8-1:0]   i_we0,
    output logic                      o_gnt0,
    output logic                      o_rvalid0,
    output logic [DATA_WIDTH-1:0]     o_rdata0,

    input  logic                      i_req1,
    input  logic                      i_lock1,
    input  logic [ADDR_WIDTH-1:0]     i_addr1,
    input  logic [DATA_WIDTH-1:0]     i_din1,
    input  logic [DATA_WIDTH/8-1:0]   i_we1,
    output logic                      o_gnt1,
    output logic                      o_rvalid1,
    output logic [DATA_WIDTH-1:0]     o_rdata1,

    output logic [ADDR_WIDTH-1:0]     o_bram_addr,
    output logic [DATA_WIDTH-1:0]     o_bram_din,
    output logic                      o_bram_en,
    output logic [DATA_WIDTH/8-1:0]   o_bram_we,
    input  logic [DATA_WIDTH-1:0]     i_bram_dout,

    output logic                      o_busy
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    arb_state_e              state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic                    gnt0_q, gnt1_q;
    logic [ADDR_WIDTH-1:0]   bram_addr_q;
    logic [DATA_WIDTH-1:0]   bram_din_q;
    logic                    bram_en_q;
    logic [DATA_WIDTH/8-1:0] bram_we_q;

    logic                    owned, owner;
    logic                    cur_req, cur_lock, peer_req;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_din;
    logic [DATA_WIDTH/8-1:0] cur_we;
    logic                    beat, cap_hit;

    rd_tag_t                 tag_in, tag_out;
    logic                    tags_busy;

    // View of whichever requester currently owns the port.
    always_comb begin
        owned    = (state_q != StIdle);
        owner    = (state_q == StOwn1) ? REQ_ID1 : REQ_ID0;
        cur_req  = (owner == REQ_ID1) ? i_req1  : i_req0;
        cur_lock = (owner == REQ_ID1) ? i_lock1 : i_lock0;
        peer_req = (owner == REQ_ID1) ? i_req0  : i_req1;
        cur_addr = (owner == REQ_ID1) ? i_addr1 : i_addr0;
        cur_din  = (owner == REQ_ID1) ? i_din1  : i_din0;
        cur_we   = (owner == REQ_ID1) ? i_we1   : i_we0;
        beat     = owned && cur_req;
    end

    // Beat counter saturates so a locked burst can run past the cap.
    always_comb begin
        cnt_inc = cnt_q;
        if (beat && (cnt_q != CntMax)) begin
            cnt_inc = cnt_q + 1'b1;
        end
        cap_hit = (cnt_inc == CntMax);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (i_req0 && i_req1) begin
                    state_d = own_state(ptr_q);
                end else if (i_req0) begin
                    state_d = StOwn0;
                end else if (i_req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (!cur_lock && (!cur_req || (cap_hit && peer_req))) begin
                    ptr_d   = ~owner;
                    state_d = peer_req ? own_state(~owner) : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_inc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            ptr_q       <= REQ_ID0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= (state_d == StOwn0);
            gnt1_q    <= (state_d == StOwn1);
            bram_en_q <= beat;
            bram_we_q <= beat ? cur_we : '0;
            if (beat) begin
                bram_addr_q <= cur_addr;
                bram_din_q  <= cur_din;
            end
        end
    end

    always_comb begin
        tag_in.valid = beat && (cur_we == '0);
        tag_in.owner = owner;
    end

    // One extra stage covers the output register in front of the BRAM.
    rd_tag_pipe #(
        .DEPTH (RD_LATENCY + 1)
    ) u_rd_tag_pipe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tag       (tag_in),
        .o_tag       (tag_out),
        .o_any_valid (tags_busy)
    );

    assign o_gnt0      = gnt0_q;
    assign o_gnt1      = gnt1_q;
    assign o_rvalid0   = tag_out.valid && (tag_out.owner == REQ_ID0);
    assign o_rvalid1   = tag_out.valid && (tag_out.owner == REQ_ID1);
    assign o_rdata0    = i_bram_dout;
    assign o_rdata1    = i_bram_dout;
    assign o_bram_addr = bram_addr_q;
    assign o_bram_din  = bram_din_q;
    assign o_bram_en   = bram_en_q;
    assign o_bram_we   = bram_we_q;
    assign o_busy      = (state_q != StIdle) || tags_busy;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 2-cycle-latency BRAM model.
module tb_bram_port_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 16;
    localparam int unsigned RL = 2;
    localparam int unsigned MB = 16;
    localparam int unsigned WW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, lock0, req1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic [WW-1:0] we0, we1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_en;
    logic [WW-1:0] bram_we;
    logic [DW-1:0] bram_dout;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RL),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req0),
        .i_lock0     (lock0),
        .i_addr0     (addr0),
        .i_din0      (din0),
        .i_we0       (we0),
        .o_gnt0      (gnt0),
        .o_rvalid0   (rvalid0),
        .o_rdata0    (rdata0),
        .i_req1      (req1),
        .i_lock1     (lock1),
        .i_addr1     (addr1),
        .i_din1      (din1),
        .i_we1       (we1),
        .o_gnt1      (gnt1),
        .o_rvalid1   (rvalid1),
        .o_rdata1    (rdata1),
        .o_bram_addr (bram_addr),
        .o_bram_din  (bram_din),
        .o_bram_en   (bram_en),
        .o_bram_we   (bram_we),
        .i_bram_dout (bram_dout),
        .o_busy      (busy)
    );

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return {32'hC0DE_0000, a};
    endfunction

    // BRAM port model: address registered by the DUT, data out two cycles later.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_p1, rd_p2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            rd_p1 <= '0;
            rd_p2 <= '0;
        end else begin
            if (bram_en) begin
                for (int b = 0; b < WW; b++) begin
                    if (bram_we[b]) mem[bram_addr[7:0]][b*8 +: 8] <= bram_din[b*8 +: 8];
                end
                rd_p1 <= mem[bram_addr[7:0]];
            end
            rd_p2 <= rd_p1;
        end
    end
    assign bram_dout = rd_p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; lock0 = 0; addr0 = '0; din0 = '0; we0 = '0;
        req1 = 0; lock1 = 0; addr1 = '0; din1 = '0; we1 = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, bram_en, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {gnt0, gnt1, rvalid0, rvalid1, bram_en, busy});
        end
        checks++;
        if ({bram_we, bram_addr, bram_din} !== '0) begin
            failures++;
            $display("FAIL reset_data we=%h addr=%h din=%h want all zero", bram_we, bram_addr, bram_din);
        end
        rst = 0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_read_burst();
        logic exp_rv;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            req0  = (c <= 4);
            addr0 = (c >= 1) ? AW'(c - 1) : '0;
            if (c == 0) begin
                checks++;
                if (gnt0 !== 1'b0) begin failures++; $display("FAIL burst_gnt_c0 got=%b want=0", gnt0); end
            end
            if (c == 1) begin
                checks++;
                if (gnt0 !== 1'b1) begin failures++; $display("FAIL burst_gnt_c1 got=%b want=1", gnt0); end
            end
            if (c == 2) begin
                checks++;
                if (bram_en !== 1'b1 || bram_addr !== 16'h0 || bram_we !== '0) begin
                    failures++;
                    $display("FAIL burst_port en=%b addr=%h we=%h want en=1 addr=0000 we=00",
                             bram_en, bram_addr, bram_we);
                end
            end
            if (c == 6) begin
                checks++;
                if ({gnt0, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL burst_release gnt0,busy=%b want=01", {gnt0, busy});
                end
            end
            if (c == 10) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL burst_drained busy=%b want=0", busy); end
            end
            exp_rv = (c >= 4 && c <= 7);
            checks++;
            if (rvalid0 !== exp_rv || rvalid1 !== 1'b0) begin
                failures++;
                $display("FAIL burst_rvalid c=%0d rv0=%b rv1=%b want rv0=%b rv1=0", c, rvalid0, rvalid1, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rdata0 !== init_word(c - 4)) begin
                    failures++;
                    $display("FAIL burst_rdata c=%0d got=%h want=%h", c, rdata0, init_word(c - 4));
                end
            end
            tick();
        end
    endtask

    task automatic test_tie();
        do_reset();
        req0 = 1; req1 = 1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL tie_first got=%b want=10", {gnt0, gnt1}); end
        tick();
        req0 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL tie_handover got=%b want=01", {gnt0, gnt1}); end
        req1 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin failures++; $display("FAIL tie_idle got=%b want=00", {gnt0, gnt1}); end
        req0 = 1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL tie_single0 got=%b want=10", {gnt0, gnt1}); end
        req0 = 0;
        tick();
        req0 = 1; req1 = 1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL tie_second got=%b want=01", {gnt0, gnt1}); end
        req0 = 0; req1 = 0;
        repeat (6) tick();
    endtask

    task automatic test_fairness();
        int beats0, beats1, first1, back0;
        do_reset();
        req0 = 1;
        tick();
        req1 = 1;
        beats0 = 0; first1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (first1 == 0) begin
                if (gnt1) first1 = c;
                else begin
                    if (gnt0 && req0) beats0++;
                    tick();
                end
            end
        end
        checks++;
        if (beats0 != 16 || first1 != 17) begin
            failures++;
            $display("FAIL fair_cap0 beats=%0d gnt1_cycle=%0d want beats=16 gnt1_cycle=17", beats0, first1);
        end
        beats1 = 0; back0 = 0;
        for (int c = 0; c < 40; c++) begin
            if (back0 == 0) begin
                if (gnt0) back0 = 1;
                else begin
                    if (gnt1 && req1) beats1++;
                    tick();
                end
            end
        end
        checks++;
        if (beats1 != 16 || back0 != 1) begin
            failures++;
            $display("FAIL fair_cap1 beats=%0d returned=%0d want beats=16 returned=1", beats1, back0);
        end
        req0 = 0; req1 = 0;
        repeat (6) tick();
    endtask

    task automatic test_lock();
        int beats;
        logic seen1;
        do_reset();
        req0 = 1; lock0 = 1;
        tick();
        req1 = 1;
        beats = 0; seen1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (gnt1) seen1 = 1;
            if (gnt0 && req0) beats++;
            tick();
        end
        checks++;
        if (beats != 40 || seen1 !== 1'b0) begin
            failures++;
            $display("FAIL lock_hold beats=%0d gnt1_seen=%b want beats=40 gnt1_seen=0", beats, seen1);
        end
        req0 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL lock_req_low got=%b want=10", {gnt0, gnt1}); end
        lock0 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL lock_release got=%b want=01", {gnt0, gnt1}); end
        req1 = 0;
        repeat (6) tick();
    endtask

    task automatic test_interleaved();
        logic exp0, exp1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            case (c)
                0: begin req0 = 1; addr0 = 16'h0010; end
                1: begin req1 = 1; addr1 = 16'h0020; din1 = {8{8'hAA}}; we1 = '1; end
                2: addr0 = 16'h0011;
                3: req0 = 0;
                5: we1 = '0;
                6: req1 = 0;
                default: ;
            endcase
            exp0 = (c == 4) || (c == 5);
            exp1 = (c == 8);
            checks++;
            if (rvalid0 !== exp0 || rvalid1 !== exp1) begin
                failures++;
                $display("FAIL ilv_rvalid c=%0d rv0=%b rv1=%b want rv0=%b rv1=%b", c, rvalid0, rvalid1, exp0, exp1);
            end
            if (exp0) begin
                checks++;
                if (rdata0 !== init_word((c == 4) ? 32'h10 : 32'h11)) begin
                    failures++;
                    $display("FAIL ilv_rdata0 c=%0d got=%h want=%h", c, rdata0,
                             init_word((c == 4) ? 32'h10 : 32'h11));
                end
            end
            if (exp1) begin
                checks++;
                if (rdata1 !== {8{8'hAA}}) begin
                    failures++;
                    $display("FAIL ilv_rdata1 got=%h want=%h", rdata1, {8{8'hAA}});
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic stale;
        do_reset();
        req1 = 1; addr1 = 16'h0030;
        tick();
        addr1 = 16'h0031;
        tick();
        addr1 = 16'h0032;
        tick();
        checks++;
        if ({gnt1, bram_en} !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_active gnt1,en=%b want=11", {gnt1, bram_en});
        end
        rst = 1;
        tick();
        rst = 0;
        req1 = 0; addr1 = '0;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, bram_en, busy} !== 6'b0 ||
            {bram_we, bram_addr, bram_din} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs ctrl=%b we=%h addr=%h din=%h want all zero",
                     {gnt0, gnt1, rvalid0, rvalid1, bram_en, busy}, bram_we, bram_addr, bram_din);
        end
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (rvalid0 || rvalid1) stale = 1;
            tick();
        end
        checks++;
        if (stale !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%b want=0", stale); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_read_burst();
        test_tie();
        test_fairness();
        test_lock();
        test_interleaved();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
